// File: rtl/instr_sequencer.sv
// Program-ROM sequencer: fetches opcode/operand pairs from address seletor,
// executes them on a small ra/rb/acc datapath and halts on disp, error or end of ROM.
module instr_sequencer #(
    parameter int unsigned MAX_ADDR = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] funcao,
    input  logic [3:0] valor,
    output logic [3:0] seletor,
    output logic [4:0] display,
    output logic       disp_valid,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [3:0] LAST_ADDR = 4'(MAX_ADDR);

    localparam logic [2:0] OP_CLRLD = 3'b000;
    localparam logic [2:0] OP_ADDLD = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_DIV2  = 3'b011;
    localparam logic [2:0] OP_DISP  = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] seletor_q, seletor_d;
    logic [4:0] display_q, display_d;
    logic       disp_valid_q, disp_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [3:0] ra_q, ra_d;
    logic [3:0] rb_q, rb_d;
    logic [4:0] acc_q, acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            seletor_q    <= 4'd0;
            display_q    <= 5'd0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            ra_q         <= 4'd0;
            rb_q         <= 4'd0;
            acc_q        <= 5'd0;
        end else begin
            state_q      <= state_d;
            seletor_q    <= seletor_d;
            display_q    <= display_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            ra_q         <= ra_d;
            rb_q         <= rb_d;
            acc_q        <= acc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        seletor_d    = seletor_q;
        display_d    = display_q;
        disp_valid_d = 1'b0;
        error_d      = error_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        acc_d        = acc_q;

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d   = FETCH;
                    seletor_d = 4'd0;
                    error_d   = 1'b0;
                end
            end
            FETCH: begin
                state_d = EXEC;
            end
            EXEC: begin
                case (funcao)
                    OP_CLRLD: begin
                        ra_d  = valor;
                        rb_d  = 4'd0;
                        acc_d = 5'd0;
                    end
                    OP_ADDLD: rb_d = valor;
                    OP_ADD:   acc_d = {1'b0, ra_q} + {1'b0, rb_q};
                    OP_DIV2:  acc_d = acc_q >> 1;
                    OP_DISP: begin
                        display_d    = acc_q;
                        disp_valid_d = 1'b1;
                        state_d      = HALT;
                    end
                    default: begin
                        error_d = 1'b1;
                        state_d = HALT;
                    end
                endcase
                // Ordinary opcodes advance; at the last address there is nowhere to go, so halt abnormally.
                if (funcao <= OP_DIV2) begin
                    if (seletor_q == LAST_ADDR) begin
                        error_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        seletor_d = seletor_q + 4'd1;
                        state_d   = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == FETCH) || (state_d == EXEC);
        done_d = (state_d == HALT);
    end

    assign seletor    = seletor_q;
    assign display    = display_q;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a program-level model expands each run into a
// per-cycle trace of expected outputs, checked every cycle, plus hand-computed literal checks.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start3;
    logic [2:0] rom_op [16];
    logic [3:0] rom_val[16];

    logic [2:0] funcao, funcao3;
    logic [3:0] valor, valor3;
    logic [3:0] seletor, seletor3;
    logic [4:0] display, display3;
    logic       disp_valid, disp_valid3;
    logic       busy, busy3;
    logic       done, done3;
    logic       error, error3;

    assign funcao  = rom_op[seletor];
    assign valor   = rom_val[seletor];
    assign funcao3 = rom_op[seletor3];
    assign valor3  = rom_val[seletor3];

    instr_sequencer #(.MAX_ADDR(15)) dut (
        .clk(clk), .rst(rst), .start(start), .funcao(funcao), .valor(valor),
        .seletor(seletor), .display(display), .disp_valid(disp_valid),
        .busy(busy), .done(done), .error(error)
    );

    instr_sequencer #(.MAX_ADDR(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .funcao(funcao3), .valor(valor3),
        .seletor(seletor3), .display(display3), .disp_valid(disp_valid3),
        .busy(busy3), .done(done3), .error(error3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int dv_count = 0;
    int cyc      = 0;
    int sel_seen[11];
    int exp_seq[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};

    typedef struct packed {
        logic [3:0] sel;
        logic [4:0] disp;
        logic       dv;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t hold;
    int   m_ra, m_rb, m_acc, m_disp;

    function automatic exp_t mk(int sel, int disp, bit dv, bit bsy, bit dn, bit err);
        exp_t e;
        e.sel  = 4'(sel);
        e.disp = 5'(disp);
        e.dv   = dv;
        e.busy = bsy;
        e.done = dn;
        e.err  = err;
        return e;
    endfunction

    // Interprets the whole program up front: two cycles per instruction, then the halt cycle.
    function automatic void build_trace(int max_addr);
        int   pc  = 0;
        bit   run = 1'b1;
        int   op, v;
        exp_t last;
        while (run) begin
            exp_q.push_back(mk(pc, m_disp, 0, 1, 0, 0));
            exp_q.push_back(mk(pc, m_disp, 0, 1, 0, 0));
            op = int'(rom_op[pc]);
            v  = int'(rom_val[pc]);
            case (op)
                0: begin m_ra = v; m_rb = 0; m_acc = 0; end
                1: m_rb = v;
                2: m_acc = m_ra + m_rb;
                3: m_acc = m_acc / 2;
                4: begin
                    m_disp = m_acc;
                    exp_q.push_back(mk(pc, m_disp, 1, 0, 1, 0));
                    run = 1'b0;
                end
                default: begin
                    exp_q.push_back(mk(pc, m_disp, 0, 0, 1, 1));
                    run = 1'b0;
                end
            endcase
            if (run) begin
                if (pc == max_addr) begin
                    exp_q.push_back(mk(pc, m_disp, 0, 0, 1, 1));
                    run = 1'b0;
                end else begin
                    pc++;
                end
            end
        end
        last    = exp_q[exp_q.size() - 1];
        last.dv = 1'b0;
        hold    = last;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            hold   = mk(0, 0, 0, 0, 0, 0);
            m_ra   = 0;
            m_rb   = 0;
            m_acc  = 0;
            m_disp = 0;
        end else if (exp_q.size() == 0 && start) begin
            build_trace(15);
        end
        #1;
        cyc++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : hold;
        if (disp_valid === 1'b1) dv_count++;
        n_checks++;
        if ({seletor, display, disp_valid, busy, done, error} !== e) begin
            n_fail++;
            $display("[TB] FAIL cycle %0d: got sel=%0d disp=%0d dv=%b busy=%b done=%b err=%b, expected sel=%0d disp=%0d dv=%b busy=%b done=%b err=%b",
                     cyc, seletor, display, disp_valid, busy, done, error,
                     e.sel, e.disp, e.dv, e.busy, e.done, e.err);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearRom(input logic [2:0] fill_op);
        for (int i = 0; i < 16; i++) begin
            rom_op[i]  = fill_op;
            rom_val[i] = 4'd0;
        end
    endtask

    task automatic setRom(input int addr, input logic [2:0] op, input logic [3:0] v);
        rom_op[addr]  = op;
        rom_val[addr] = v;
    endtask

    // Called at a negedge: one-cycle start pulse (seen at E0), then run for the given cycles.
    task automatic applyStimulus(input int cycles, input bit with_dut3);
        start  = 1'b1;
        start3 = with_dut3;
        @(negedge clk);
        start  = 1'b0;
        start3 = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic loadNominal();
        clearRom(3'b111);
        setRom(0, 3'b000, 4'd4);
        setRom(1, 3'b001, 4'd2);
        setRom(2, 3'b010, 4'd0);
        setRom(3, 3'b011, 4'd0);
        setRom(4, 3'b100, 4'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        clearRom(3'b111);
        repeat (2) @(negedge clk);
        checkOutput("reset seletor", seletor, 0);
        checkOutput("reset display", display, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] nominal program, start held high");
        loadNominal();
        dv_count = 0;
        start = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            sel_seen[i] = int'(seletor);
        end
        checkOutput("nominal disp_valid after E10", disp_valid, 1);
        checkOutput("nominal display after E10", display, 3);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) checkOutput($sformatf("nominal seletor seq %0d", i), sel_seen[i], exp_seq[i]);
        checkOutput("nominal display held", display, 3);
        checkOutput("nominal done", done, 1);
        checkOutput("nominal error", error, 0);
        checkOutput("nominal busy", busy, 0);
        checkOutput("nominal disp_valid pulses", dv_count, 1);

        $display("[TB] restart after halt, max operands");
        clearRom(3'b111);
        setRom(0, 3'b000, 4'd15);
        setRom(1, 3'b001, 4'd15);
        setRom(2, 3'b010, 4'd0);
        setRom(3, 3'b100, 4'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart seletor", seletor, 0);
        checkOutput("restart done cleared", done, 0);
        checkOutput("restart busy", busy, 1);
        repeat (3) @(negedge clk);
        checkOutput("restart display kept", display, 3);
        repeat (8) @(negedge clk);
        checkOutput("max operands display", display, 30);

        $display("[TB] div2 variants");
        clearRom(3'b111);
        setRom(0, 3'b000, 4'd15);
        setRom(1, 3'b001, 4'd15);
        setRom(2, 3'b010, 4'd0);
        setRom(3, 3'b011, 4'd0);
        setRom(4, 3'b100, 4'd0);
        applyStimulus(12, 1'b0);
        checkOutput("div2 of 30", display, 15);
        clearRom(3'b111);
        setRom(0, 3'b000, 4'd4);
        setRom(1, 3'b001, 4'd3);
        setRom(2, 3'b010, 4'd0);
        setRom(3, 3'b011, 4'd0);
        setRom(4, 3'b100, 4'd0);
        applyStimulus(12, 1'b0);
        checkOutput("div2 of odd 7", display, 3);

        $display("[TB] reset during EXEC of addr 2");
        loadNominal();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midreset seletor", seletor, 0);
        checkOutput("midreset display", display, 0);
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset done", done, 0);
        checkOutput("midreset error", error, 0);
        checkOutput("midreset disp_valid", disp_valid, 0);
        dv_count = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("after reset idle busy", busy, 0);
        checkOutput("after reset idle done", done, 0);
        checkOutput("after reset no disp_valid", dv_count, 0);

        $display("[TB] illegal opcode");
        clearRom(3'b111);
        setRom(0, 3'b000, 4'd5);
        setRom(1, 3'b110, 4'd9);
        dv_count = 0;
        applyStimulus(8, 1'b0);
        checkOutput("illegal error", error, 1);
        checkOutput("illegal done", done, 1);
        checkOutput("illegal seletor", seletor, 1);
        checkOutput("illegal display", display, 0);
        checkOutput("illegal disp_valid pulses", dv_count, 0);

        $display("[TB] run off end of ROM");
        clearRom(3'b010);
        applyStimulus(40, 1'b1);
        checkOutput("runoff seletor", seletor, 15);
        checkOutput("runoff error", error, 1);
        checkOutput("runoff done", done, 1);
        checkOutput("runoff3 seletor", seletor3, 3);
        checkOutput("runoff3 error", error3, 1);
        checkOutput("runoff3 done", done3, 1);
        checkOutput("runoff3 busy", busy3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction reader and executor for the program ROM.
- Drives the ROM address `seletor` and samples the returned `funcao` (3-bit opcode) and `valor` (4-bit operand).
- Executes five opcodes on a small internal datapath: ra, rb, acc.
- Publishes the displayed result and halts on `disp`, on an illegal opcode, or on running off the end of the address space.

Parameters:
- MAX_ADDR, 15, last legal ROM address. Range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; begins execution from address 0 when in IDLE or HALT.
- funcao  input  3  opcode returned by the ROM for `seletor`.
- valor  input  4  operand returned by the ROM for `seletor`.
- seletor  output  4  ROM address (program counter), registered.
- display  output  5  last value written by `disp`, registered.
- disp_valid  output  1  one-cycle pulse when `display` is updated.
- busy  output  1  high in FETCH and EXEC.
- done  output  1  high in HALT.
- error  output  1  high in HALT if the halt was abnormal.

Behaviour:
- Opcodes:
  - 000 clrld: ra<=valor, rb<=0, acc<=0.
  - 001 addld: rb<=valor.
  - 010 add: acc<={0,ra}+{0,rb}. 5-bit result, cannot overflow (max 30).
  - 011 div2: acc<=acc>>1, logical shift, LSB discarded.
  - 100 disp: display<=acc, disp_valid<=1, then halt.
  - 101/110/111: illegal; set error, then halt. No datapath change.
  - `valor` is ignored for add, div2 and disp.
- Reset (asynchronous, any state):
  - state=IDLE.
  - seletor=0, display=0, disp_valid=0, busy=0, done=0, error=0.
  - ra=0, rb=0, acc=0.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE: start=1 at an edge -> FETCH, seletor=0, busy=1.
  - FETCH: one settle cycle; `seletor` is held stable and the ROM output is not sampled. Next edge -> EXEC.
  - EXEC: samples funcao/valor at the edge and executes.
    - Normal opcode and seletor<MAX_ADDR: seletor<=seletor+1, -> FETCH.
    - Normal opcode and seletor==MAX_ADDR: no wrap; seletor holds, error<=1, -> HALT.
    - disp: -> HALT, error stays 0.
    - Illegal opcode: error<=1, -> HALT.
  - HALT: busy=0, done=1, outputs hold.
    - start=1 at an edge -> FETCH; clears done and error, seletor=0.
    - ra, rb, acc and display are NOT cleared; they are overwritten only by later instructions.
- Timing:
  - start sampled at edge E0; instruction k executes at edge E(2k+2).
  - Every instruction costs exactly 2 cycles.
  - disp_valid is high only in the cycle following the disp edge; it is cleared at the next edge unconditionally.
- start is ignored while busy=1.
- busy, done and error are registered with the state, not decoded combinationally from inputs.
- Reset mid-program aborts immediately with no pending effects. No disp_valid may appear after reset until a new disp executes.

Test Plan:
- Nominal program: ROM {0:clrld 4, 1:addld 2, 2:add, 3:div2, 4:disp}, start pulse at E0 -> seletor sequence 0,0,1,1,2,2,3,3,4,4. Then display=3 with disp_valid=1 for exactly one cycle after E10; done=1, error=0, busy=0.
- Max operands: ROM {clrld 15, addld 15, add, disp} -> display=30. Variant with div2 inserted before disp -> display=15; an odd acc (e.g. 7 from clrld 4 / addld 3 / add) gives 3 after div2.
- Illegal opcode: ROM addr1 funcao=3'b110 -> halt after E4 with error=1, done=1; display stays 0; disp_valid never pulses.
- Run-off end: ROM with no disp, all add (MAX_ADDR=15) -> seletor reaches 15; after executing addr 15, error=1, done=1, and seletor stays 15 (no wrap to 0). With MAX_ADDR=3, the same halt occurs at seletor=3.
- Start handling: start held high throughout the nominal program -> no restart while busy. After HALT, a start pulse restarts from seletor=0 with done/error cleared; display keeps 3 until the next disp.
- Reset mid-program: assert rst asynchronously (between edges) during the EXEC of addr 2 -> all outputs go to 0 immediately. After release, state is IDLE and stays there until start.
